// File: rtl/relay_mem_pkg.sv
// Shared types and constants for the relay memory responder.
package relay_mem_pkg;

    // Default bus widths for the sequencer's address and data buses.
    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Width of the wait-state counter, so WAIT_CYCLES can be 0..15.
    localparam int CNT_WIDTH = 4;

    // Responder handshake states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/relay_mem_array.sv
// Byte-wide SRAM model: synchronous write, asynchronous read.
// Addresses at or above DEPTH are unmapped. Writes to them are dropped and reads return zero.
module relay_mem_array #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32768
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  in_range;
    logic [IDX_WIDTH-1:0]  index;

    assign in_range = ({1'b0, addr} < DEPTH_LIMIT);
    assign index    = addr[IDX_WIDTH-1:0];

    // Commit a write on the clock edge only when the address is mapped. Contents are never reset.
    always_ff @(posedge clock) begin
        if (write_en && in_range) begin
            mem[index] <= write_data;
        end
    end

    // Combinational read. An unmapped address reads as zero.
    always_comb begin
        read_data = '0;
        if (in_range) begin
            read_data = mem[index];
        end
    end

endmodule

// File: rtl/relay_memory_responder.sv
// Memory-side responder for the sequencer. It uses a four-phase read/write handshake with
// WAIT_CYCLES wait states. All outputs are registered.
module relay_memory_responder
    import relay_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int DEPTH       = 32768,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] addr_bus,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_en,
    output logic                  mem_ready,
    output logic                  protocol_error
);

    localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(WAIT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam bit                   NO_WAIT   = (WAIT_CYCLES == 0);

    state_t                state;
    logic [CNT_WIDTH-1:0]  wait_count;
    logic [ADDR_WIDTH-1:0] addr_latch;
    logic [DATA_WIDTH-1:0] data_latch;
    logic                  is_write;

    logic                  req_held;
    logic                  direct_ack;
    logic                  wait_done;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] access_addr;
    logic [DATA_WIDTH-1:0] access_data;
    logic [DATA_WIDTH-1:0] read_data;

    // Decode the accepted request and pick the address and data for the array.
    // With zero wait states, IDLE goes straight to ACK, so the array must see the live bus values.
    // The commit is gated by reset_n, so a write cannot land while reset is held.
    always_comb begin
        req_held    = is_write ? mem_write : mem_read;
        direct_ack  = (state == IDLE) && (mem_read ^ mem_write) && NO_WAIT;
        wait_done   = (state == WAIT) && req_held && (wait_count == CNT_ONE);
        commit      = reset_n && ((direct_ack && mem_write) || (wait_done && is_write));
        access_addr = (state == IDLE) ? addr_bus : addr_latch;
        access_data = (state == IDLE) ? data_in  : data_latch;
    end

    relay_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clock      (clock),
        .write_en   (commit),
        .addr       (access_addr),
        .write_data (access_data),
        .read_data  (read_data)
    );

    // Handshake FSM, wait counter, request latches and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            wait_count     <= '0;
            addr_latch     <= '0;
            data_latch     <= '0;
            is_write       <= 1'b0;
            data_out       <= '0;
            data_out_en    <= 1'b0;
            mem_ready      <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read && mem_write) begin
                        protocol_error <= 1'b1;
                    end else if (mem_read || mem_write) begin
                        addr_latch <= addr_bus;
                        data_latch <= data_in;
                        is_write   <= mem_write;
                        wait_count <= WAIT_LOAD;
                        if (NO_WAIT) begin
                            state     <= ACK;
                            mem_ready <= 1'b1;
                            if (!mem_write) begin
                                data_out    <= read_data;
                                data_out_en <= 1'b1;
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req_held) begin
                        protocol_error <= 1'b1;
                        state          <= IDLE;
                    end else if (wait_count == CNT_ONE) begin
                        wait_count <= '0;
                        state      <= ACK;
                        mem_ready  <= 1'b1;
                        if (!is_write) begin
                            data_out    <= read_data;
                            data_out_en <= 1'b1;
                        end
                    end else begin
                        wait_count <= wait_count - CNT_ONE;
                    end
                end
                ACK: begin
                    if (!req_held) begin
                        state       <= IDLE;
                        mem_ready   <= 1'b0;
                        data_out_en <= 1'b0;
                        data_out    <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relay_memory_responder.sv
// Self-checking bench for relay_memory_responder. It drives two instances: one with two wait
// states and one with none. A scoreboard queue holds the response expected for each access.
module tb_relay_memory_responder;

    typedef struct {
        int         lat;
        logic [7:0] data;
        logic       en;
    } exp_t;

    logic        clock;
    logic        reset_n;

    logic [15:0] addr2, addr0;
    logic        rd2, rd0, wr2, wr0;
    logic [7:0]  din2, din0;
    logic [7:0]  dout2, dout0;
    logic        en2, en0, rdy2, rdy0, err2, err0;

    logic        sel;
    logic [7:0]  cur_dout;
    logic        cur_en, cur_rdy, cur_err;

    exp_t        sb[$];
    logic [7:0]  model2 [int];
    logic [7:0]  model0 [int];

    int          n_vec;
    int          n_err;

    relay_memory_responder #(.WAIT_CYCLES(2)) dut2 (
        .clock          (clock),
        .reset_n        (reset_n),
        .addr_bus       (addr2),
        .mem_read       (rd2),
        .mem_write      (wr2),
        .data_in        (din2),
        .data_out       (dout2),
        .data_out_en    (en2),
        .mem_ready      (rdy2),
        .protocol_error (err2)
    );

    relay_memory_responder #(.WAIT_CYCLES(0)) dut0 (
        .clock          (clock),
        .reset_n        (reset_n),
        .addr_bus       (addr0),
        .mem_read       (rd0),
        .mem_write      (wr0),
        .data_in        (din0),
        .data_out       (dout0),
        .data_out_en    (en0),
        .mem_ready      (rdy0),
        .protocol_error (err0)
    );

    // Free-running clock with a 10-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Route the outputs of the instance under test to one set of signals.
    always_comb begin
        cur_dout = sel ? dout0 : dout2;
        cur_en   = sel ? en0   : en2;
        cur_rdy  = sel ? rdy0  : rdy2;
        cur_err  = sel ? err0  : err2;
    end

    task automatic drive(input bit use0, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [7:0] d);
        if (use0) begin
            rd0 = rd; wr0 = wr; addr0 = a; din0 = d;
        end else begin
            rd2 = rd; wr2 = wr; addr2 = a; din2 = d;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One full four-phase access with the expected result pushed before the request is driven.
    task automatic access(input bit use0, input bit wr, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        int   lat;
        bit   got;
        e.lat  = use0 ? 1 : 3;
        e.en   = !wr;
        e.data = 8'h00;
        if (wr) begin
            if (a < 16'h8000) begin
                if (use0) model0[int'(a)] = d;
                else      model2[int'(a)] = d;
            end
        end else if (a < 16'h8000) begin
            e.data = use0 ? model0[int'(a)] : model2[int'(a)];
        end
        sb.push_back(e);
        sel = use0;
        @(negedge clock);
        drive(use0, !wr, wr, a, d);
        lat = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clock); #1;
            lat++;
            if (cur_rdy) got = 1;
            else begin
                n_vec++;
                if (cur_en !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL en_during_wait: got %b, expected 0", cur_en);
                end
            end
        end
        e = sb.pop_front();
        n_vec++;
        if (!got || lat != e.lat) begin
            n_err++;
            $display("[TB] FAIL ready_latency addr=%h: got %0d (seen=%0d), expected %0d", a, lat, got, e.lat);
        end
        n_vec++;
        if (cur_dout !== e.data || cur_en !== e.en) begin
            n_err++;
            $display("[TB] FAIL response addr=%h: got data=%h en=%b, expected data=%h en=%b",
                     a, cur_dout, cur_en, e.data, e.en);
        end
        @(posedge clock); #1;
        n_vec++;
        if (cur_rdy !== 1'b1 || cur_dout !== e.data || cur_en !== e.en) begin
            n_err++;
            $display("[TB] FAIL ack_hold: got rdy=%b data=%h en=%b, expected rdy=1 data=%h en=%b",
                     cur_rdy, cur_dout, cur_en, e.data, e.en);
        end
        @(negedge clock);
        drive(use0, 1'b0, 1'b0, a, d);
        @(posedge clock); #1;
        n_vec++;
        if (cur_rdy !== 1'b0 || cur_en !== 1'b0 || cur_dout !== 8'h00) begin
            n_err++;
            $display("[TB] FAIL release: got rdy=%b en=%b data=%h, expected 0/0/00",
                     cur_rdy, cur_en, cur_dout);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        sel = 1'b0;
        #12;
        n_vec++;
        if ({dout2, en2, rdy2, err2} !== 11'h0 || {dout0, en0, rdy0, err0} !== 11'h0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got %h/%h, expected 000/000",
                     {dout2, en2, rdy2, err2}, {dout0, en0, rdy0, err0});
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        access(1'b0, 1'b1, 16'h0010, 8'h5A);
        access(1'b0, 1'b0, 16'h0010, 8'h00);
        access(1'b0, 1'b1, 16'h0020, 8'h11);
        access(1'b0, 1'b1, 16'h7FFF, 8'hC3);
        access(1'b0, 1'b0, 16'h7FFF, 8'h00);
    endtask

    task automatic test_zero_wait();
        access(1'b1, 1'b1, 16'h0010, 8'h5A);
        access(1'b1, 1'b0, 16'h0010, 8'h00);
        access(1'b1, 1'b1, 16'h0011, 8'h96);
        access(1'b1, 1'b0, 16'h0011, 8'h00);
    endtask

    task automatic test_unmapped();
        access(1'b0, 1'b1, 16'h8000, 8'hFF);
        access(1'b0, 1'b0, 16'h8000, 8'h00);
        access(1'b1, 1'b1, 16'hFFFF, 8'hFF);
        access(1'b1, 1'b0, 16'hFFFF, 8'h00);
        n_vec++;
        if (err2 !== 1'b0 || err0 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL unmapped_no_error: got %b/%b, expected 0/0", err2, err0);
        end
    endtask

    task automatic test_errors();
        sel = 1'b0;
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b1, 16'h0010, 8'h77);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            n_vec++;
            if (err2 !== 1'b1 || rdy2 !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL both_requests cycle %0d: got err=%b rdy=%b, expected err=1 rdy=0",
                         i, err2, rdy2);
            end
        end
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 16'h0020, 8'h00);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b1, 16'h0020, 8'hAA);
        @(posedge clock); #1;
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 16'h0020, 8'hAA);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            n_vec++;
            if (rdy2 !== 1'b0 || err2 !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL abort cycle %0d: got rdy=%b err=%b, expected rdy=0 err=1",
                         i, rdy2, err2);
            end
        end
        access(1'b0, 1'b0, 16'h0020, 8'h00);
        n_vec++;
        if (err2 !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL error_sticky: got %b, expected 1", err2);
        end
        pulse_reset();
        #1;
        n_vec++;
        if (err2 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL error_cleared: got %b, expected 0", err2);
        end
    endtask

    task automatic test_reset_during_ack();
        exp_t e;
        bit   got;
        e.lat  = 3;
        e.en   = 1'b1;
        e.data = model2[16];
        sb.push_back(e);
        sel = 1'b0;
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clock); #1;
            if (rdy2) got = 1;
        end
        e = sb.pop_front();
        n_vec++;
        if (!got || dout2 !== e.data) begin
            n_err++;
            $display("[TB] FAIL pre_reset_read: got seen=%0d data=%h, expected seen=1 data=%h",
                     got, dout2, e.data);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({dout2, en2, rdy2, err2} !== 11'h0) begin
            n_err++;
            $display("[TB] FAIL async_reset: got %h, expected 000", {dout2, en2, rdy2, err2});
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0010, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        access(1'b0, 1'b0, 16'h0010, 8'h00);
        access(1'b1, 1'b0, 16'h0010, 8'h00);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_write_read();
        test_zero_wait();
        test_unmapped();
        test_errors();
        test_reset_during_ack();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
